// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// 3-sample majority helper used by the bit sampler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Received-word handshake: the receiver presents a word plus error flags,
// the consumer accepts it with rx_ready.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_error;
  logic                 parity_error;

  modport master (
    output rx_data, rx_valid, frame_error, parity_error,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_error, parity_error,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Serial-line front end: 2-flop synchronizer, falling-edge detect, oversample
// tick counter and a majority vote over the three mid-bit samples.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic baud_tick,
  input  logic rx_serial,
  input  logic clear,
  output logic fall,
  output logic bit_valid,
  output logic bit_value
);

  localparam int            CW     = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] SMP_A  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SMP_B  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SMP_C  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(OVERSAMPLE - 1);

  logic          meta, sync, prev;
  logic [CW-1:0] cnt;
  logic          smp_a, smp_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchronizer and history flops reset to the idle-high line level so
      // that releasing reset can never look like a start edge.
      meta  <= 1'b1;
      sync  <= 1'b1;
      prev  <= 1'b1;
      cnt   <= '0;
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else begin
      meta <= rx_serial;
      sync <= meta;
      prev <= sync;
      if (clear) begin
        cnt <= '0;
      end else if (baud_tick) begin
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        if (cnt == SMP_A) smp_a <= sync;
        if (cnt == SMP_B) smp_b <= sync;
      end
    end
  end

  // The third sample is taken live, so the vote is ready on the third sample tick.
  assign fall      = prev & ~sync;
  assign bit_valid = baud_tick && !clear && (cnt == SMP_C);
  assign bit_value = majority3(smp_a, smp_b, sync);

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start/data/parity/stop sequencing on voted bits, with a
// valid/ready output holding one word and an overrun pulse on a dropped frame.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick,
  input  logic              rx_serial,
  uart_rx_frame_if.master   rx_if,
  output logic              overrun,
  output logic              busy
);

  localparam int             BCW       = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
  localparam bit             PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  rx_state_t            state;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q, stop_cnt;
  logic                 fall, bit_valid, bit_value, start_det;

  assign start_det = (state == IDLE) && fall;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .rx_serial (rx_serial),
    .clear     (start_det),
    .fall      (fall),
    .bit_valid (bit_valid),
    .bit_value (bit_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      bit_cnt            <= '0;
      shift_q            <= '0;
      perr_q             <= 1'b0;
      ferr_q             <= 1'b0;
      stop_cnt           <= 1'b0;
      rx_if.rx_data      <= '0;
      rx_if.rx_valid     <= 1'b0;
      rx_if.frame_error  <= 1'b0;
      rx_if.parity_error <= 1'b0;
      overrun            <= 1'b0;
      busy               <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the later completion branch
      // can override this acceptance clear within the same clock.
      overrun <= 1'b0;
      if (rx_if.rx_valid && rx_if.rx_ready) rx_if.rx_valid <= 1'b0;

      case (state)
        IDLE: if (fall) begin
          state <= START;
          busy  <= 1'b1;
        end
        START: if (bit_valid) begin
          if (bit_value) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= DATA;
            bit_cnt  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            stop_cnt <= 1'b0;
          end
        end
        DATA: if (bit_valid) begin
          shift_q <= {bit_value, shift_q[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + BCW'(1);
          if (bit_cnt == LAST_BIT) state <= (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: if (bit_valid) begin
          perr_q <= ((^shift_q) ^ bit_value) != PAR_MODE;
          state  <= STOP;
        end
        STOP: if (bit_valid) begin
          if (stop_cnt == LAST_STOP) begin
            state <= IDLE;
            busy  <= 1'b0;
            // A pending word is kept unless it is being accepted on this clock.
            if (!rx_if.rx_valid || rx_if.rx_ready) begin
              rx_if.rx_data      <= shift_q;
              rx_if.frame_error  <= ferr_q | ~bit_value;
              rx_if.parity_error <= perr_q;
              rx_if.rx_valid     <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            ferr_q   <= ferr_q | ~bit_value;
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: a default-configuration receiver and an
// even-parity receiver, driven with bit-accurate frames at 32 clks per bit.
module tb_uart_rx_frame;

  logic clk = 1'b0;
  logic rst_n;
  logic baud_tick = 1'b0;
  logic rx_a, rx_b;
  logic ovr_a, ovr_b, busy_a, busy_b;
  int   checks = 0;
  int   errors = 0;
  int   ovr_cnt_a = 0;
  int   ovr0;

  uart_rx_frame_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_frame_if #(.DATA_BITS(8)) bus_b ();

  uart_rx_frame u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .rx_serial (rx_a),
    .rx_if     (bus_a.master),
    .overrun   (ovr_a),
    .busy      (busy_a)
  );

  uart_rx_frame #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .rx_serial (rx_b),
    .rx_if     (bus_b.master),
    .overrun   (ovr_b),
    .busy      (busy_b)
  );

  always #5 clk = ~clk;

  // Tick on every other clock: 16 ticks = 32 clks per bit.
  initial forever begin
    @(posedge clk);
    #1 baud_tick = ~baud_tick;
  end

  always @(posedge clk) if (ovr_a === 1'b1) ovr_cnt_a <= ovr_cnt_a + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench on a negedge whose following posedge carries a tick.
  task automatic align();
    @(negedge clk);
    if (baud_tick !== 1'b1) @(negedge clk);
  endtask

  task automatic drive_bits(input bit which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) rx_b = bits[i];
      else       rx_a = bits[i];
      repeat (32) @(negedge clk);
    end
  endtask

  task automatic accept_a();
    bus_a.rx_ready = 1'b1;
    @(negedge clk);
    bus_a.rx_ready = 1'b0;
    check("accept_a_valid_low", bus_a.rx_valid, 0);
  endtask

  task automatic accept_b();
    bus_b.rx_ready = 1'b1;
    @(negedge clk);
    bus_b.rx_ready = 1'b0;
    check("accept_b_valid_low", bus_b.rx_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    bus_a.rx_ready = 1'b0;
    bus_b.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus_a.rx_valid, 0);
    check("rst_data", bus_a.rx_data, 0);
    check("rst_ferr", bus_a.frame_error, 0);
    check("rst_perr", bus_a.parity_error, 0);
    check("rst_ovr", ovr_a, 0);
    check("rst_busy", busy_a, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // 0xA5, exact latency: stop vote on the posedge after negedge T+310.
    align();
    drive_bits(0, {7'h0, 8'hA5, 1'b0}, 9);
    rx_a = 1'b1;
    repeat (22) @(negedge clk);
    check("a5_valid_before_vote", bus_a.rx_valid, 0);
    check("a5_busy_in_stop", busy_a, 1);
    @(negedge clk);
    check("a5_valid", bus_a.rx_valid, 1);
    check("a5_data", bus_a.rx_data, 8'hA5);
    check("a5_ferr", bus_a.frame_error, 0);
    check("a5_perr", bus_a.parity_error, 0);
    check("a5_busy_idle", busy_a, 0);
    repeat (9) @(negedge clk);
    check("a5_hold_data", bus_a.rx_data, 8'hA5);
    accept_a();

    // 0x3C with a zero stop bit.
    align();
    drive_bits(0, {6'h0, 1'b0, 8'h3C, 1'b0}, 10);
    rx_a = 1'b1;
    repeat (32) @(negedge clk);
    check("3c_valid", bus_a.rx_valid, 1);
    check("3c_data", bus_a.rx_data, 8'h3C);
    check("3c_ferr", bus_a.frame_error, 1);
    accept_a();

    // Break: 12 bit periods low yields exactly one zero word.
    ovr0 = ovr_cnt_a;
    align();
    rx_a = 1'b0;
    repeat (12 * 32) @(negedge clk);
    rx_a = 1'b1;
    repeat (64) @(negedge clk);
    check("brk_valid", bus_a.rx_valid, 1);
    check("brk_data", bus_a.rx_data, 0);
    check("brk_ferr", bus_a.frame_error, 1);
    check("brk_one_word", ovr_cnt_a - ovr0, 0);
    check("brk_busy", busy_a, 0);
    accept_a();

    // Overrun: 0x11 held, 0x22 dropped.
    ovr0 = ovr_cnt_a;
    align();
    drive_bits(0, {6'h0, 1'b1, 8'h11, 1'b0}, 10);
    repeat (32) @(negedge clk);
    check("ovr_11_data", bus_a.rx_data, 8'h11);
    align();
    drive_bits(0, {6'h0, 1'b1, 8'h22, 1'b0}, 10);
    repeat (32) @(negedge clk);
    check("ovr_pulse_once", ovr_cnt_a - ovr0, 1);
    check("ovr_keep_data", bus_a.rx_data, 8'h11);
    check("ovr_keep_valid", bus_a.rx_valid, 1);

    // Third word completes on the very clock the old word is accepted.
    align();
    drive_bits(0, {7'h0, 8'h33, 1'b0}, 9);
    rx_a = 1'b1;
    repeat (22) @(negedge clk);
    check("same_clk_old_data", bus_a.rx_data, 8'h11);
    bus_a.rx_ready = 1'b1;
    @(negedge clk);
    bus_a.rx_ready = 1'b0;
    check("same_clk_valid", bus_a.rx_valid, 1);
    check("same_clk_data", bus_a.rx_data, 8'h33);
    check("same_clk_no_ovr", ovr_cnt_a - ovr0, 1);
    repeat (9) @(negedge clk);
    accept_a();

    // False start: 3-tick glitch in idle.
    align();
    rx_a = 1'b0;
    repeat (6) @(negedge clk);
    rx_a = 1'b1;
    repeat (4) @(negedge clk);
    check("glitch_busy", busy_a, 1);
    repeat (54) @(negedge clk);
    check("glitch_idle", busy_a, 0);
    check("glitch_no_valid", bus_a.rx_valid, 0);

    // 0x55 with a one-tick dip on the first majority sample of data bit 0.
    align();
    rx_a = 1'b0;
    repeat (32) @(negedge clk);
    rx_a = 1'b1;
    repeat (16) @(negedge clk);
    rx_a = 1'b0;
    repeat (2) @(negedge clk);
    rx_a = 1'b1;
    repeat (14) @(negedge clk);
    drive_bits(0, {8'h0, 1'b1, 7'h2A}, 8);
    repeat (32) @(negedge clk);
    check("vote_55_valid", bus_a.rx_valid, 1);
    check("vote_55_data", bus_a.rx_data, 8'h55);
    check("vote_55_ferr", bus_a.frame_error, 0);

    // Reset in the middle of DATA while a word is still pending.
    align();
    drive_bits(0, {7'h0, 8'h96, 1'b0}, 4);
    check("mid_busy", busy_a, 1);
    rst_n = 1'b0;
    rx_a = 1'b1;
    #1;
    check("mid_rst_valid", bus_a.rx_valid, 0);
    check("mid_rst_data", bus_a.rx_data, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_ferr", bus_a.frame_error, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (64) @(negedge clk);
    check("post_rst_no_word", bus_a.rx_valid, 0);
    align();
    drive_bits(0, {6'h0, 1'b1, 8'h96, 1'b0}, 10);
    repeat (32) @(negedge clk);
    check("96_valid", bus_a.rx_valid, 1);
    check("96_data", bus_a.rx_data, 8'h96);
    check("96_ferr", bus_a.frame_error, 0);
    accept_a();

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong and 1 is right.
    align();
    drive_bits(1, {5'h0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (32) @(negedge clk);
    check("par_bad_valid", bus_b.rx_valid, 1);
    check("par_bad_data", bus_b.rx_data, 8'h07);
    check("par_bad_perr", bus_b.parity_error, 1);
    check("par_bad_ferr", bus_b.frame_error, 0);
    accept_b();
    align();
    drive_bits(1, {5'h0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (32) @(negedge clk);
    check("par_ok_data", bus_b.rx_data, 8'h07);
    check("par_ok_perr", bus_b.parity_error, 0);
    accept_b();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
